// File: rtl/gated_burst_monitor_if.sv
// Bus bundle between a gated burst clock source/observer and the monitor.
// frame_valid is a valid-only strobe with no ready: the consumer must capture
// m1_meas/x_meas/m2_meas/frame_err in the single cycle frame_valid is high.
// Those outputs then hold until the next strobe.
interface gated_burst_monitor_if #(
    parameter int M1_WIDTH = 10,
    parameter int M2_WIDTH = 10,
    parameter int X_WIDTH  = 5
);
    logic                enable;
    logic                burst_clk;
    logic                burst_phase;
    logic [M1_WIDTH-1:0] m1_meas;
    logic [X_WIDTH-1:0]  x_meas;
    logic [M2_WIDTH-1:0] m2_meas;
    logic                frame_valid;
    logic                frame_err;
    logic [1:0]          fsm_state;

    modport master (
        output enable, burst_clk, burst_phase,
        input  m1_meas, x_meas, m2_meas, frame_valid, frame_err, fsm_state
    );

    modport slave (
        input  enable, burst_clk, burst_phase,
        output m1_meas, x_meas, m2_meas, frame_valid, frame_err, fsm_state
    );
endinterface

// File: rtl/gated_burst_monitor.sv
// Receive-side checker for a gated burst clock stream.
// For each complete frame (burst phase followed by a silent phase), it measures:
//   - the high width of the first pulse,
//   - the number of pulses,
//   - the length of the silent phase.
// It reports these on the next burst edge.
// The FSM state is exposed on bus.fsm_state for observation.
module gated_burst_monitor #(
    parameter int M1_WIDTH = 10,
    parameter int M2_WIDTH = 10,
    parameter int X_WIDTH  = 5
) (
    input logic                  clk,
    input logic                  reset,
    gated_burst_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        SILENT = 2'd2
    } state_t;

    localparam logic [M1_WIDTH-1:0] HI_MAX  = '1;
    localparam logic [X_WIDTH-1:0]  X_MAX   = '1;
    localparam logic [M2_WIDTH-1:0] SIL_MAX = '1;
    localparam logic [M1_WIDTH-1:0] HI_ONE  = M1_WIDTH'(1);
    localparam logic [X_WIDTH-1:0]  X_ONE   = X_WIDTH'(1);
    localparam logic [M2_WIDTH-1:0] SIL_ONE = M2_WIDTH'(1);

    state_t              state, state_n;
    logic                clk_d, phase_d;
    logic [M1_WIDTH-1:0] hi_cnt, hi_n;
    logic [M1_WIDTH-1:0] first_w, first_w_n;
    logic [X_WIDTH-1:0]  pulse_cnt, pulse_n;
    logic [M2_WIDTH-1:0] sil_cnt, sil_n;
    logic                first_done, first_done_n;
    logic                mism, mism_n;
    logic                sat, sat_n;
    logic                report;
    logic                start;

    logic rise_c, fall_c, rise_p, fall_p;

    assign rise_c = bus.burst_clk & ~clk_d;
    assign fall_c = ~bus.burst_clk & clk_d;
    assign rise_p = bus.burst_phase & ~phase_d;
    assign fall_p = ~bus.burst_phase & phase_d;

    assign bus.fsm_state = state;

    // Previous-cycle samples for edge detection.
    // These keep tracking while disabled, so that re-enabling mid-burst
    // cannot fake a phase edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_d   <= 1'b0;
            phase_d <= 1'b0;
        end else begin
            clk_d   <= bus.burst_clk;
            phase_d <= bus.burst_phase;
        end
    end

    // Next-state and accumulator update logic.
    always_comb begin
        state_n      = state;
        hi_n         = hi_cnt;
        first_w_n    = first_w;
        pulse_n      = pulse_cnt;
        sil_n        = sil_cnt;
        first_done_n = first_done;
        mism_n       = mism;
        sat_n        = sat;
        report       = 1'b0;
        start        = 1'b0;

        if (!bus.enable) begin
            state_n      = IDLE;
            hi_n         = '0;
            first_w_n    = '0;
            pulse_n      = '0;
            sil_n        = '0;
            first_done_n = 1'b0;
            mism_n       = 1'b0;
            sat_n        = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A partial frame seen after reset or enable is skipped.
                    if (rise_p) begin
                        state_n = BURST;
                        start   = 1'b1;
                    end
                end
                BURST: begin
                    if (fall_p) begin
                        // A pulse still high here is abandoned without a width compare.
                        state_n = SILENT;
                        sil_n   = SIL_ONE;
                    end else begin
                        if (rise_c) begin
                            hi_n = HI_ONE;
                            if (pulse_cnt == X_MAX) begin
                                sat_n = 1'b1;
                            end else begin
                                pulse_n = pulse_cnt + 1'b1;
                            end
                        end else if (bus.burst_clk) begin
                            if (hi_cnt == HI_MAX) begin
                                sat_n = 1'b1;
                            end else begin
                                hi_n = hi_cnt + 1'b1;
                            end
                        end
                        if (fall_c) begin
                            if (!first_done) begin
                                first_w_n    = hi_cnt;
                                first_done_n = 1'b1;
                            end else if (hi_cnt != first_w) begin
                                mism_n = 1'b1;
                            end
                        end
                    end
                end
                SILENT: begin
                    if (rise_p) begin
                        report  = 1'b1;
                        state_n = BURST;
                        start   = 1'b1;
                    end else if (sil_cnt == SIL_MAX) begin
                        sat_n = 1'b1;
                    end else begin
                        sil_n = sil_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase

            // The phase-edge cycle opens a new frame.
            // A pulse rising on that same edge is counted.
            if (start) begin
                pulse_n      = rise_c ? X_ONE : '0;
                hi_n         = {{(M1_WIDTH-1){1'b0}}, bus.burst_clk};
                first_w_n    = '0;
                first_done_n = 1'b0;
                mism_n       = 1'b0;
                sat_n        = 1'b0;
            end
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hi_cnt     <= '0;
            first_w    <= '0;
            pulse_cnt  <= '0;
            sil_cnt    <= '0;
            first_done <= 1'b0;
            mism       <= 1'b0;
            sat        <= 1'b0;
        end else begin
            state      <= state_n;
            hi_cnt     <= hi_n;
            first_w    <= first_w_n;
            pulse_cnt  <= pulse_n;
            sil_cnt    <= sil_n;
            first_done <= first_done_n;
            mism       <= mism_n;
            sat        <= sat_n;
        end
    end

    // Report registers: loaded once per closed frame, otherwise held.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.m1_meas     <= '0;
            bus.x_meas      <= '0;
            bus.m2_meas     <= '0;
            bus.frame_err   <= 1'b0;
            bus.frame_valid <= 1'b0;
        end else begin
            bus.frame_valid <= report;
            if (report) begin
                bus.m1_meas   <= first_w;
                bus.x_meas    <= pulse_cnt;
                bus.m2_meas   <= sil_cnt;
                bus.frame_err <= mism | sat;
            end
        end
    end
endmodule

// File: tb/tb_gated_burst_monitor.sv
// Directed bench for gated_burst_monitor.
// Expected frame reports are queued before the frame closes.
// Each frame_valid pops the queue and compares every field.
module tb_gated_burst_monitor;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gated_burst_monitor_if bus ();

    gated_burst_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {err, m1[9:0], x[4:0], m2[9:0]}
    logic [25:0] exp_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    int valid_cyc = -1;
    int c0;
    int v0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_frame(input int m1, input int x, input int m2, input int err);
        logic [25:0] e;
        e = {err[0], m1[9:0], x[4:0], m2[9:0]};
        exp_q.push_back(e);
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic ph, input logic bc);
        logic [25:0] e;
        bus.burst_phase = ph;
        bus.burst_clk   = bc;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.frame_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("m1_meas", {22'd0, bus.m1_meas}, {22'd0, e[24:15]});
                check("x_meas", {27'd0, bus.x_meas}, {27'd0, e[14:10]});
                check("m2_meas", {22'd0, bus.m2_meas}, {22'd0, e[9:0]});
                check("frame_err", {31'd0, bus.frame_err}, {31'd0, e[25]});
            end
        end
        prev_valid = bus.frame_valid;
    endtask

    task automatic silent(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    // npulse pulses of hi high / lo low cycles.
    // Pulse number odd_idx (1-based) is odd_hi cycles high instead.
    task automatic burst(input int npulse, input int hi, input int lo,
                         input int odd_idx, input int odd_hi);
        for (int p = 1; p <= npulse; p++) begin
            repeat ((p == odd_idx) ? odd_hi : hi) step(1'b1, 1'b1);
            repeat (lo) step(1'b1, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m1"}, {22'd0, bus.m1_meas}, 32'd0);
        check({tag, "_x"}, {27'd0, bus.x_meas}, 32'd0);
        check({tag, "_m2"}, {22'd0, bus.m2_meas}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.frame_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, bus.frame_err}, 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.burst_phase = 1'b0;
        bus.burst_clk   = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        check_zero("reset");

        reset      = 1'b0;
        bus.enable = 1'b1;
        silent(3);

        // Basic frame: 4 pulses of 2/2 and 10 silent cycles.
        // The report must appear 1 cycle after the phase rises.
        burst(4, 2, 2, 0, 0);
        silent(10);
        expect_frame(2, 4, 10, 0);
        c0 = cyc;
        burst(4, 2, 2, 3, 3);
        check("latency", valid_cyc, c0 + 1);
        check("valid_count_1", valid_cnt, 1);

        // Third pulse was 3 high: width mismatch.
        silent(10);
        expect_frame(2, 4, 10, 1);
        burst(4, 2, 2, 0, 0);

        // Long silence saturates sil_cnt.
        silent(1100);
        expect_frame(2, 4, 1023, 1);
        burst(4, 2, 2, 0, 0);
        silent(10);
        expect_frame(2, 4, 10, 0);

        // Enable dropped mid-burst: the broken frame is never reported.
        burst(2, 2, 2, 0, 0);
        bus.enable = 1'b0;
        burst(5, 2, 2, 0, 0);
        bus.enable = 1'b1;
        burst(2, 2, 2, 0, 0);
        silent(10);
        v0 = valid_cnt;
        burst(4, 2, 2, 0, 0);
        check("no_valid_broken", valid_cnt, v0);
        check("hold_m1", {22'd0, bus.m1_meas}, 32'd2);
        check("hold_x", {27'd0, bus.x_meas}, 32'd4);
        check("hold_m2", {22'd0, bus.m2_meas}, 32'd10);
        check("hold_err", {31'd0, bus.frame_err}, 32'd0);
        silent(7);
        expect_frame(2, 4, 7, 0);
        burst(4, 2, 2, 0, 0);

        // Reset mid-silence clears the outputs.
        // The next frame after reset is not reported.
        silent(5);
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        check_zero("mid_reset");
        silent(3);
        v0 = valid_cnt;
        burst(4, 2, 2, 0, 0);
        check("no_valid_after_reset", valid_cnt, v0);
        silent(4);
        expect_frame(2, 4, 4, 0);

        // Pulse rising on the phase edge counts; 1-cycle pulses.
        burst(3, 1, 1, 0, 0);
        silent(5);
        expect_frame(1, 3, 5, 0);
        burst(4, 2, 2, 0, 0);

        // Single-cycle silence.
        silent(1);
        expect_frame(2, 4, 1, 0);

        // 40 pulses saturate the pulse counter at 31.
        burst(40, 1, 1, 0, 0);
        silent(2);
        expect_frame(1, 31, 2, 1);
        burst(4, 2, 2, 0, 0);
        silent(3);

        check("exp_q_drained", exp_q.size(), 0);
        check("valid_count_total", valid_cnt, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
